// File: rtl/flappy_pkg.sv
// Shared constants, coordinate type and scroller FSM states for the flappy pipeline.
package flappy_pkg;

  typedef logic [10:0] coord_t;
  typedef logic [2:0]  speed_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FROZEN
  } state_e;

  localparam coord_t      SCREEN_W     = 11'd640;
  localparam coord_t      PIPE_SPACING = 11'd320;
  localparam coord_t      BIRD_X       = 11'd160;
  localparam coord_t      GAP_MIN      = 11'd112;
  localparam coord_t      GAP_DEFAULT  = 11'd240;
  localparam speed_t      SPEED        = 3'd2;
  localparam speed_t      SPEED_MAX    = 3'd4;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;

  // A pipe that would reach x<=0 re-enters two spacings further right.
  function automatic coord_t next_x(input coord_t x, input speed_t s);
    if (x <= coord_t'(s)) begin
      return x + PIPE_SPACING + PIPE_SPACING - coord_t'(s);
    end
    return x - coord_t'(s);
  endfunction

  function automatic logic crossed(input coord_t old_x, input coord_t new_x);
    return (old_x >= BIRD_X) && (new_x < BIRD_X);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11); free-running, only hard reset reseeds it.
module lfsr16
  import flappy_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic        fb;

  assign fb    = value_q[15] ^ value_q[13] ^ value_q[12] ^ value_q[10];
  assign value = value_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= LFSR_SEED;
    end else begin
      value_q <= {value_q[14:0], fb};
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Two-pipe horizontal scroller with wrap, gap reload and bird-pass pulse.
// Optional PIPE_SPEEDUP_EN: speed rises by 1 every 8 passes, saturating at 4.
module pipe_scroller
  import flappy_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        game_reset,
  input  logic        tick,
  input  logic        start,
  input  logic        gameover,
  output logic [10:0] pipe1_x,
  output logic [10:0] pipe2_x,
  output logic [10:0] pipe1_y,
  output logic [10:0] pipe2_y,
  output logic        pipe_passed,
  output logic        running
);

  state_e      state_q, state_d;
  coord_t      p1x_q, p1x_d, p2x_q, p2x_d;
  coord_t      p1y_q, p1y_d, p2y_q, p2y_d;
  logic        pass_q, pass_d;
  logic [15:0] lfsr;
  speed_t      speed;
  logic        move_en;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr)
  );

  // Gameover in the same cycle as tick freezes without applying motion.
  assign move_en = (state_q == ST_RUN) && tick && !gameover;

  always_comb begin
    state_d = state_q;
    p1x_d   = p1x_q;
    p2x_d   = p2x_q;
    p1y_d   = p1y_q;
    p2y_d   = p2y_q;
    pass_d  = 1'b0;

    case (state_q)
      ST_IDLE:   if (start)    state_d = ST_RUN;
      ST_RUN:    if (gameover) state_d = ST_FROZEN;
      ST_FROZEN: state_d = ST_FROZEN;
      default:   state_d = ST_IDLE;
    endcase

    if (move_en) begin
      p1x_d = next_x(p1x_q, speed);
      p2x_d = next_x(p2x_q, speed);
      if (p1x_q <= coord_t'(speed)) p1y_d = GAP_MIN + coord_t'(lfsr[7:0]);
      if (p2x_q <= coord_t'(speed)) p2y_d = GAP_MIN + coord_t'(lfsr[15:8]);
      pass_d = crossed(p1x_q, p1x_d) | crossed(p2x_q, p2x_d);
    end

    if (game_reset) begin
      state_d = ST_IDLE;
      p1x_d   = SCREEN_W;
      p2x_d   = SCREEN_W + PIPE_SPACING;
      p1y_d   = GAP_DEFAULT;
      p2y_d   = GAP_DEFAULT;
      pass_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      p1x_q   <= SCREEN_W;
      p2x_q   <= SCREEN_W + PIPE_SPACING;
      p1y_q   <= GAP_DEFAULT;
      p2y_q   <= GAP_DEFAULT;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p1x_q   <= p1x_d;
      p2x_q   <= p2x_d;
      p1y_q   <= p1y_d;
      p2y_q   <= p2y_d;
      pass_q  <= pass_d;
    end
  end

`ifdef PIPE_SPEEDUP_EN
  logic [2:0] pass_cnt_q;
  speed_t     speed_q;

  assign speed = speed_q;

  // Speed steps on the same edge that emits the 8th pulse, so the next tick uses it.
  always_ff @(posedge clock) begin
    if (reset || game_reset) begin
      pass_cnt_q <= '0;
      speed_q    <= SPEED;
    end else if (pass_d) begin
      pass_cnt_q <= pass_cnt_q + 3'd1;
      if ((pass_cnt_q == 3'd7) && (speed_q < SPEED_MAX)) begin
        speed_q <= speed_q + 3'd1;
      end
    end
  end
`else
  assign speed = SPEED;
`endif

  assign pipe1_x     = p1x_q;
  assign pipe2_x     = p2x_q;
  assign pipe1_y     = p1y_q;
  assign pipe2_y     = p2y_q;
  assign pipe_passed = pass_q;
  assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: vector table, corner sequences, random run vs model.
`timescale 1ns/1ps
module tb_pipe_scroller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        game_reset = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        gameover = 1'b0;
  logic [10:0] pipe1_x, pipe2_x, pipe1_y, pipe2_y;
  logic        pipe_passed, running;

  int n_checks = 0;
  int n_err    = 0;

  pipe_scroller dut (
    .clock       (clock),
    .reset       (reset),
    .game_reset  (game_reset),
    .tick        (tick),
    .start       (start),
    .gameover    (gameover),
    .pipe1_x     (pipe1_x),
    .pipe2_x     (pipe2_x),
    .pipe1_y     (pipe1_y),
    .pipe2_y     (pipe2_y),
    .pipe_passed (pipe_passed),
    .running     (running)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Reference model: 0=idle 1=run 2=frozen, plain integer positions.
  int          m_p1x, m_p2x, m_p1y, m_p2y, m_spd, m_state, m_total;
  bit          m_pass;
  logic [15:0] m_lfsr = 16'hACE1;

  task automatic model_defaults();
    m_p1x = 640; m_p2x = 960; m_p1y = 240; m_p2y = 240;
    m_state = 0; m_pass = 0; m_spd = 2; m_total = 0;
  endtask

  task automatic model_step(input bit tk, input bit st, input bit go, input bit gr, input bit rs);
    logic [15:0] nl;
    int o1, o2;
    if (rs) begin
      model_defaults();
      m_lfsr = 16'hACE1;
      return;
    end
    nl = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    m_pass = 0;
    if (gr) begin
      model_defaults();
    end else if (m_state == 0) begin
      if (st) m_state = 1;
    end else if (m_state == 1) begin
      if (go) m_state = 2;
      else if (tk) begin
        o1 = m_p1x; o2 = m_p2x;
        m_p1x = o1 - m_spd;
        m_p2x = o2 - m_spd;
        if (m_p1x <= 0) begin m_p1x += 640; m_p1y = 112 + int'(m_lfsr[7:0]); end
        if (m_p2x <= 0) begin m_p2x += 640; m_p2y = 112 + int'(m_lfsr[15:8]); end
        m_pass = (o1 >= 160 && m_p1x < 160) || (o2 >= 160 && m_p2x < 160);
        if (m_pass) begin
          m_total++;
`ifdef PIPE_SPEEDUP_EN
          if (m_total % 8 == 0 && m_spd < 4) m_spd++;
`endif
        end
      end
    end
    m_lfsr = nl;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, sample 1ns after the edge, compare to model.
  task automatic cyc(input bit tk, input bit st, input bit go, input bit gr, input bit rs);
    tick = tk; start = st; gameover = go; game_reset = gr; reset = rs;
    model_step(tk, st, go, gr, rs);
    @(posedge clock);
    #1;
    chk("mdl_p1x", int'(pipe1_x), m_p1x);
    chk("mdl_p2x", int'(pipe2_x), m_p2x);
    chk("mdl_p1y", int'(pipe1_y), m_p1y);
    chk("mdl_p2y", int'(pipe2_y), m_p2y);
    chk("mdl_pass", int'(pipe_passed), int'(m_pass));
    chk("mdl_run", int'(running), (m_state == 1) ? 1 : 0);
  endtask

  typedef struct {
    bit tk;
    bit st;
    bit go;
    int p1x;
    int p2x;
    bit run;
  } vec_t;

  vec_t vecs[$];

  initial begin : main
    int          sv1, sv2, prev, nw, exp_y;
    logic [15:0] lsnap;
    int          targets[4];
    int          deltas[4];

    // Table: idle ticks ignored, start, ten ticks, start ignored while running.
    for (int i = 0; i < 3; i++) vecs.push_back('{1, 0, 0, 640, 960, 0});
    vecs.push_back('{0, 1, 0, 640, 960, 1});
    for (int i = 1; i <= 10; i++) vecs.push_back('{1, 0, 0, 640 - 2 * i, 960 - 2 * i, 1});
    vecs.push_back('{1, 1, 0, 618, 938, 1});
    vecs.push_back('{0, 0, 0, 618, 938, 1});

    repeat (2) @(posedge clock);
    cyc(0, 0, 0, 0, 1);
    chk("rst_p1x", int'(pipe1_x), 640);
    chk("rst_p2x", int'(pipe2_x), 960);
    chk("rst_p1y", int'(pipe1_y), 240);
    chk("rst_run", int'(running), 0);
    chk("rst_pass", int'(pipe_passed), 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].tk, vecs[i].st, vecs[i].go, 0, 0);
      chk("tbl_p1x", int'(pipe1_x), vecs[i].p1x);
      chk("tbl_p2x", int'(pipe2_x), vecs[i].p2x);
      chk("tbl_run", int'(running), int'(vecs[i].run));
      chk("tbl_pass", int'(pipe_passed), 0);
    end

    // Crossing the bird column: 162 -> 160 no pulse, 160 -> 158 one pulse.
    for (int i = 0; i < 1000 && m_p1x != 162; i++) cyc(1, 0, 0, 0, 0);
    chk("reach162", int'(pipe1_x), 162);
    cyc(1, 0, 0, 0, 0);
    chk("at160_x", int'(pipe1_x), 160);
    chk("at160_pass", int'(pipe_passed), 0);
    cyc(1, 0, 0, 0, 0);
    chk("at158_x", int'(pipe1_x), 158);
    chk("at158_pass", int'(pipe_passed), 1);
    cyc(0, 0, 0, 0, 0);
    chk("pulse_1cyc", int'(pipe_passed), 0);
    chk("hold_x", int'(pipe1_x), 158);

    // Wrap at x=2 reloads gap from the LFSR low byte of that cycle.
    for (int i = 0; i < 1000 && m_p1x != 2; i++) cyc(1, 0, 0, 0, 0);
    chk("reach2", int'(pipe1_x), 2);
    lsnap = m_lfsr;
    exp_y = 112 + int'(lsnap[7:0]);
    cyc(1, 0, 0, 0, 0);
    chk("wrap_x", int'(pipe1_x), 640);
    chk("wrap_y", int'(pipe1_y), exp_y);
    chk("wrap_y_range", (pipe1_y >= 11'd112 && pipe1_y <= 11'd367) ? 1 : 0, 1);

    // Gameover with tick: freeze wins; frozen ignores tick and start.
    sv1 = m_p1x; sv2 = m_p2x;
    cyc(1, 0, 1, 0, 0);
    chk("go_p1x", int'(pipe1_x), sv1);
    chk("go_p2x", int'(pipe2_x), sv2);
    chk("go_run", int'(running), 0);
    cyc(1, 1, 0, 0, 0);
    chk("frz_p1x", int'(pipe1_x), sv1);
    chk("frz_run", int'(running), 0);
    cyc(0, 0, 0, 1, 0);
    chk("gr_p1x", int'(pipe1_x), 640);
    chk("gr_p2x", int'(pipe2_x), 960);
    chk("gr_p1y", int'(pipe1_y), 240);
    chk("gr_p2y", int'(pipe2_y), 240);
    chk("gr_run", int'(running), 0);

    // Mid-run restart, and reset taking priority over game_reset.
    cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0);
    chk("mid_p1x", int'(pipe1_x), 630);
    cyc(1, 0, 0, 1, 0);
    chk("midgr_p1x", int'(pipe1_x), 640);
    chk("midgr_run", int'(running), 0);
    cyc(1, 0, 0, 1, 1);
    chk("rstpri_p2x", int'(pipe2_x), 960);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 299) == 0),
          ($urandom_range(0, 999) == 0));
    end

`ifdef PIPE_SPEEDUP_EN
    targets = '{8, 16, 24, 32};
    deltas  = '{3, 4, 4, 4};
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 20000 && m_total < targets[t]; i++) cyc(1, 0, 0, 0, 0);
      chk("passes_reached", m_total, targets[t]);
      if (pipe1_x > 11'd5) begin
        prev = int'(pipe1_x); cyc(1, 0, 0, 0, 0); nw = int'(pipe1_x);
      end else begin
        prev = int'(pipe2_x); cyc(1, 0, 0, 0, 0); nw = int'(pipe2_x);
      end
      chk("speed_delta", prev - nw, deltas[t]);
    end
`else
    targets = '{0, 0, 0, 0};
    deltas  = '{2, 2, 2, 2};
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 1000 && m_total < 8 + targets[0]; i++) cyc(1, 0, 0, 0, 0);
    prev = int'(pipe1_x) > 5 ? int'(pipe1_x) : int'(pipe2_x);
    sv1 = int'(pipe1_x) > 5 ? 1 : 2;
    cyc(1, 0, 0, 0, 0);
    nw = (sv1 == 1) ? int'(pipe1_x) : int'(pipe2_x);
    chk("const_speed_delta", prev - nw, deltas[3]);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_scroller.md
PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 SCREEN_W, 640, x coordinate at which a freshly spawned pipe enters.
REQ-002 PIPE_SPACING, 320, horizontal distance between pipe1 and pipe2.
REQ-003 SPEED, 2, pixels moved per frame tick (base speed).
REQ-004 BIRD_X, 160, fixed bird x column used for pass detection.
REQ-005 GAP_MIN, 112, minimum gap-centre y; gap y = GAP_MIN + 8-bit random value.
REQ-006 GAP_DEFAULT, 240, gap y after reset/game_reset.
REQ-007 clock  input  1  system clock; reset  input  1  synchronous, active-high, clears all state.
REQ-008 game_reset  input  1  synchronous restart; returns to IDLE, keeps LFSR state.
REQ-009 tick  input  1  one-cycle frame pulse; all motion happens only on tick cycles.
REQ-010 start  input  1  level/pulse; leaves IDLE when high.
REQ-011 gameover  input  1  from score stage; freezes motion.
REQ-012 pipe1_x, pipe2_x  output  11  pipe left-edge x; pipe1_y, pipe2_y  output  11  gap-centre y.
REQ-013 pipe_passed  output  1  one-cycle pulse when any pipe crosses BIRD_X.
REQ-014 running  output  1  high in RUN state only.

Function
REQ-015 FSM states IDLE, RUN, FROZEN; IDLE->RUN when start=1; RUN->FROZEN when gameover=1; FROZEN->IDLE only via game_reset or reset.
REQ-016 In IDLE and FROZEN, positions hold; pipe_passed stays 0.
REQ-017 In RUN, on each tick, each pipe_x decreases by current speed; outputs update the cycle after tick (1-cycle latency).
REQ-018 Wrap: on a tick where pipe_x <= speed, that pipe_x becomes pipe_x + 2*PIPE_SPACING - speed and its y is reloaded with GAP_MIN + lfsr[7:0].
REQ-019 Both pipes wrapping on the same tick take lfsr[7:0] and lfsr[15:8] respectively (pipe1 low byte).
REQ-020 pipe_passed pulses for one cycle on a tick where old pipe_x >= BIRD_X and new pipe_x < BIRD_X; never two pulses per tick.
REQ-021 LFSR 16-bit Fibonacci, taps 16,14,13,11, advances every clock cycle in all states; never reaches zero.
REQ-022 gameover and tick in same cycle in RUN: freeze wins, no movement applied.
REQ-023 start ignored outside IDLE; tick ignored outside RUN.
REQ-024 All arithmetic unsigned 11-bit; no value exceeds SCREEN_W + PIPE_SPACING.

Reset
REQ-025 reset: state IDLE, pipe1_x=SCREEN_W (640), pipe2_x=SCREEN_W+PIPE_SPACING (960), both y=GAP_DEFAULT (240), pipe_passed=0, running=0, speed=SPEED, LFSR=16'hACE1.
REQ-026 game_reset: same as reset except LFSR unchanged; reset has priority over game_reset; mid-RUN restart takes effect next cycle.

Configuration
REQ-027 PIPE_SPEEDUP_EN defined: 3-bit pass counter; every 8th pipe_passed increments speed by 1, saturating at 4; cleared by reset/game_reset.
REQ-028 PIPE_SPEEDUP_EN undefined: speed constant at SPEED, no pass counter logic present.

Structure
REQ-029 Shared package flappy_pkg holds SCREEN_W, PIPE_SPACING, BIRD_X, GAP_MIN, GAP_DEFAULT defaults, 11-bit coord_t typedef, and FSM state enum.
REQ-030 LFSR is a sub-module lfsr16 (clock, reset, value[15:0]).

Verification
REQ-031 reset, 3 ticks without start -> pipe1_x=640, pipe2_x=960, running=0.
REQ-032 start, then 10 ticks -> pipe1_x=620, pipe2_x=940, running=1, pipe_passed never high.
REQ-033 run until pipe1_x=162 then tick -> pipe1_x=160, no pulse; next tick -> 158, pipe_passed=1 for exactly one cycle.
REQ-034 pipe1_x=2 then tick -> pipe1_x=640, pipe1_y=112+lfsr[7:0] sampled that cycle, within 112..367.
REQ-035 gameover and tick same cycle -> positions unchanged, running=0; game_reset -> positions back to 640/960/240.
REQ-036 PIPE_SPEEDUP_EN defined, 8 passes -> per-tick delta 3; after 16 and 24 passes delta 4, after 32 still 4.
